// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch slice: reset PC, ROM geometry,
// fetch state encoding and the queue entry layout.
package fetch_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          ROM_AW    = 8;
    localparam int          ROM_DEPTH = 110;
    localparam int          DBG_MAXW  = 2;
    localparam logic [31:0] NOP       = 32'h0000_0000;

    typedef enum logic {
        RUN       = 1'b0,
        ADEL_HOLD = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf2.sv
// Two-entry FIFO between fetch and decode. slot0 is always the head, so the
// decode-facing outputs come straight from a register.
module fetch_buf2
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    fetch_entry_t slot0, slot1;
    logic [1:0]   count;
    logic         do_pop, do_push;

    assign do_pop  = pop & (count != 2'd0);
    assign do_push = push & ((count != 2'd2) | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) slot0 <= din;
                    else               slot1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                // Simultaneous push and pop keeps the count; new data lands behind the survivor.
                2'b11: begin
                    if (count == 2'd1) begin
                        slot0 <= din;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head  = slot0;
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, applies redirects, queues fetched
// words for decode and shares the ROM port with a debug reader.
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC,
    parameter int          ROM_AW   = fetch_pkg::ROM_AW,
    parameter int          DBG_MAXW = fetch_pkg::DBG_MAXW
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_inst,
    input  logic              redirect_vld,
    input  logic [31:0]       redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       id_inst,
    output logic [31:0]       id_pc,
    output logic              id_adel,
    output logic [31:0]       fetch_pc,
    input  logic              dbg_req,
    input  logic [ROM_AW-1:0] dbg_addr,
    output logic              dbg_ack,
    output logic [31:0]       dbg_inst
);
    import fetch_pkg::*;

    localparam int                WAIT_W   = $clog2(DBG_MAXW + 2);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(DBG_MAXW);

    fetch_state_t      state, state_nxt;
    logic [31:0]       pc, pc_nxt;
    logic [WAIT_W-1:0] dbg_wait, dbg_wait_nxt;
    logic              fetch_want, fetch_grant, dbg_pending, dbg_grant;
    logic              pop, push, full, empty, adel_fetch;
    fetch_entry_t      push_entry, head;

    // Debug normally takes idle ROM cycles, but steals one once it has waited DBG_MAXW cycles.
    assign pop         = id_valid & id_ready;
    assign fetch_want  = (state == RUN) && (!full || pop);
    assign dbg_pending = dbg_req & ~dbg_ack;
    assign dbg_grant   = dbg_pending && (!fetch_want || (dbg_wait == WAIT_MAX));
    assign fetch_grant = fetch_want & ~dbg_grant;
    assign push        = fetch_grant & ~redirect_vld;
    assign adel_fetch  = (pc[1:0] != 2'b00);
    assign rom_addr    = dbg_grant ? dbg_addr : pc[ROM_AW+1:2];
    assign push_entry  = '{pc: pc, inst: (adel_fetch ? NOP : rom_inst), adel: adel_fetch};

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        dbg_wait_nxt = dbg_wait;
        if (dbg_grant)        dbg_wait_nxt = '0;
        else if (dbg_pending) dbg_wait_nxt = dbg_wait + 1'b1;
        if (redirect_vld) begin
            pc_nxt    = redirect_pc;
            state_nxt = RUN;
        end else if (fetch_grant) begin
            // A misaligned PC produces a single error entry and then parks until redirected.
            if (adel_fetch) state_nxt = ADEL_HOLD;
            else            pc_nxt    = pc + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            pc       <= RESET_PC;
            dbg_wait <= '0;
            dbg_ack  <= 1'b0;
            dbg_inst <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            dbg_wait <= dbg_wait_nxt;
            dbg_ack  <= dbg_grant;
            if (dbg_grant) dbg_inst <= rom_inst;
        end
    end

    fetch_buf2 u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_vld),
        .din   (push_entry),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    assign id_valid = ~empty;
    assign id_inst  = head.inst;
    assign id_pc    = head.pc;
    assign id_adel  = head.adel;
    assign fetch_pc = pc;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed scenarios plus a randomized run, checked
// against an in-order fetch-stream model and a debug-latency tracker.
module tb_inst_fetch_ctrl;
    import fetch_pkg::*;

    logic        clk, rst;
    logic [7:0]  rom_addr;
    logic [31:0] rom_inst;
    logic        redirect_vld;
    logic [31:0] redirect_pc;
    logic        id_valid, id_ready, id_adel;
    logic [31:0] id_inst, id_pc, fetch_pc;
    logic        dbg_req, dbg_ack;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_inst;

    logic [31:0] rom_mem [0:ROM_DEPTH-1];

    int tests = 0;
    int failures = 0;

    logic [31:0] exp_pc;
    logic        adel_pending, adel_done;
    logic [31:0] adel_pc;
    logic        hold_prev, hold_adel;
    logic [31:0] hold_pc, hold_inst;
    logic        dbg_out, dbg_new;
    logic [7:0]  dbg_out_addr, dbg_new_addr;
    int          dbg_lat;

    inst_fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .rom_addr     (rom_addr),
        .rom_inst     (rom_inst),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_inst      (id_inst),
        .id_pc        (id_pc),
        .id_adel      (id_adel),
        .fetch_pc     (fetch_pc),
        .dbg_req      (dbg_req),
        .dbg_addr     (dbg_addr),
        .dbg_ack      (dbg_ack),
        .dbg_inst     (dbg_inst)
    );

    always #5 clk = ~clk;

    // Asynchronous instruction ROM; words past the populated depth read as zero.
    always_comb begin
        rom_inst = NOP;
        if (int'(rom_addr) < ROM_DEPTH) rom_inst = rom_mem[rom_addr];
    end

    function automatic logic [31:0] romAt(input int idx);
        if (idx < ROM_DEPTH) return rom_mem[idx];
        return NOP;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic resetDut();
        rst          = 1'b1;
        redirect_vld = 1'b0;
        redirect_pc  = '0;
        id_ready     = 1'b0;
        dbg_req      = 1'b0;
        dbg_addr     = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_id_valid", id_valid, 0);
        checkOutput("rst_id_inst",  id_inst,  0);
        checkOutput("rst_id_pc",    id_pc,    0);
        checkOutput("rst_id_adel",  id_adel,  0);
        checkOutput("rst_dbg_ack",  dbg_ack,  0);
        checkOutput("rst_dbg_inst", dbg_inst, 0);
        checkOutput("rst_fetch_pc", fetch_pc, RESET_PC);
        rst          = 1'b0;
        exp_pc       = RESET_PC;
        adel_pending = 1'b0;
        adel_done    = 1'b0;
        hold_prev    = 1'b0;
        dbg_out      = 1'b0;
        dbg_new      = 1'b0;
    endtask

    // One clock cycle: drive inputs, check the visible state against the model, then advance.
    task automatic applyStimulus(input logic rdv, input logic [31:0] rpc, input logic rdy);
        logic acked;
        acked = 1'b0;
        if (hold_prev) begin
            checkOutput("hold_valid", id_valid, 1);
            checkOutput("hold_pc",    id_pc,    hold_pc);
            checkOutput("hold_inst",  id_inst,  hold_inst);
            checkOutput("hold_adel",  id_adel,  hold_adel);
        end
        if (adel_done) checkOutput("adel_hold_idle", id_valid, 0);

        if (dbg_ack) begin
            acked = 1'b1;
            if (dbg_out) begin
                checkOutput("dbg_inst", dbg_inst, romAt(int'(dbg_out_addr)));
                checkOutput("dbg_latency_ok", (dbg_lat <= DBG_MAXW + 1) ? 1 : 0, 1);
            end else begin
                checkOutput("dbg_spurious_ack", 1, 0);
            end
            dbg_out = 1'b0;
            dbg_req = 1'b0;
        end else if (dbg_out && dbg_lat > DBG_MAXW + 1) begin
            checkOutput("dbg_ack_timeout", dbg_lat, DBG_MAXW + 1);
            dbg_out = 1'b0;
            dbg_req = 1'b0;
        end
        if (dbg_new && !dbg_out && !acked) begin
            dbg_req      = 1'b1;
            dbg_addr     = dbg_new_addr;
            dbg_out      = 1'b1;
            dbg_out_addr = dbg_new_addr;
            dbg_lat      = 0;
            dbg_new      = 1'b0;
        end

        redirect_vld = rdv;
        redirect_pc  = rpc;
        id_ready     = rdy;

        if (id_valid && rdy) begin
            if (adel_pending) begin
                checkOutput("adel_flag", id_adel, 1);
                checkOutput("adel_pc",   id_pc,   adel_pc);
                checkOutput("adel_inst", id_inst, 0);
                adel_pending = 1'b0;
                adel_done    = 1'b1;
            end else begin
                checkOutput("pop_adel", id_adel, 0);
                checkOutput("pop_pc",   id_pc,   exp_pc);
                checkOutput("pop_inst", id_inst, romAt(int'(exp_pc[9:2])));
                exp_pc = exp_pc + 32'd4;
            end
        end
        hold_prev = id_valid & ~rdy & ~rdv;
        hold_pc   = id_pc;
        hold_inst = id_inst;
        hold_adel = id_adel;

        if (rdv) begin
            adel_done = 1'b0;
            if (rpc[1:0] != 2'b00) begin
                adel_pending = 1'b1;
                adel_pc      = rpc;
            end else begin
                adel_pending = 1'b0;
                exp_pc       = rpc;
            end
        end

        @(posedge clk);
        #1;
        redirect_vld = 1'b0;
        if (dbg_out) dbg_lat++;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < ROM_DEPTH; i++) rom_mem[i] = 32'h3C00_0000 + 32'(i) * 32'h0000_0101;
        rom_mem[0]  = 32'hAC01_0000;
        rom_mem[1]  = 32'hAC02_0004;
        rom_mem[13] = 32'h2401_0001;
        rom_mem[18] = 32'hFFFF_FFFF;

        // Streaming from reset, one instruction per cycle.
        resetDut();
        applyStimulus(0, 0, 1);
        checkOutput("first_valid", id_valid, 1);
        checkOutput("first_pc",    id_pc,    32'h0);
        checkOutput("first_inst",  id_inst,  32'hAC01_0000);
        applyStimulus(0, 0, 1);
        checkOutput("second_pc",   id_pc,    32'h4);
        checkOutput("second_inst", id_inst,  32'hAC02_0004);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 1);
            checkOutput("stream_valid", id_valid, 1);
        end

        // Back-pressure: queue fills with the first two words and fetch stalls.
        resetDut();
        repeat (5) applyStimulus(0, 0, 0);
        checkOutput("stall_pc",       id_pc,    32'h0);
        checkOutput("stall_inst",     id_inst,  32'hAC01_0000);
        checkOutput("stall_fetch_pc", fetch_pc, 32'h8);

        // Debug read with the queue full is served immediately.
        dbg_new = 1'b1;
        dbg_new_addr = 8'd13;
        applyStimulus(0, 0, 0);
        checkOutput("dbg13_ack",  dbg_ack,  1);
        checkOutput("dbg13_inst", dbg_inst, 32'h2401_0001);
        repeat (4) applyStimulus(0, 0, 1);

        // Debug read while fetch is busy every cycle must still complete in bounded time.
        dbg_new = 1'b1;
        dbg_new_addr = 8'd18;
        repeat (6) applyStimulus(0, 0, 1);
        checkOutput("dbg18_inst", dbg_inst, 32'hFFFF_FFFF);

        // Redirect while full and popping.
        repeat (3) applyStimulus(0, 0, 0);
        applyStimulus(1, 32'h34, 1);
        checkOutput("redir_flushed", id_valid, 0);
        applyStimulus(0, 0, 0);
        checkOutput("redir_pc",   id_pc,   32'h34);
        checkOutput("redir_inst", id_inst, 32'h2401_0001);

        // Misaligned redirect yields a single address-error entry, then silence.
        applyStimulus(1, 32'h36, 0);
        applyStimulus(0, 0, 0);
        checkOutput("adel_valid", id_valid, 1);
        checkOutput("adel_head",  id_adel,  1);
        checkOutput("adel_hpc",   id_pc,    32'h36);
        checkOutput("adel_hinst", id_inst,  32'h0);
        repeat (2) applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 1);
        dbg_new = 1'b1;
        dbg_new_addr = 8'd1;
        repeat (4) applyStimulus(0, 0, 1);
        applyStimulus(1, 32'h0, 0);
        applyStimulus(0, 0, 0);
        checkOutput("resume_pc",   id_pc,   32'h0);
        checkOutput("resume_inst", id_inst, 32'hAC01_0000);

        // Reset in mid-operation with a full queue.
        repeat (3) applyStimulus(0, 0, 0);
        resetDut();

        // Randomized traffic.
        for (int n = 0; n < 800; n++) begin
            logic        rdv, rdy;
            logic [31:0] tgt;
            rdy = ($urandom_range(0, 3) != 0);
            rdv = adel_done ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 39) == 0);
            tgt = 32'($urandom_range(0, ROM_DEPTH - 1)) * 32'd4;
            if ($urandom_range(0, 3) == 0) tgt = tgt + 32'($urandom_range(1, 3));
            if (!dbg_out && !dbg_new && $urandom_range(0, 7) == 0) begin
                dbg_new      = 1'b1;
                dbg_new_addr = 8'($urandom_range(0, 119));
            end
            applyStimulus(rdv, tgt, rdy);
        end
        dbg_new = 1'b0;
        repeat (6) applyStimulus(0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
